// File: rtl/swervolf_sseg_pkg.sv
// Shared types and the hex -> seven-segment table for the SweRVolf display scanner.
// Segment encoding is active low with bit 0 = a ... bit 6 = g.
package swervolf_sseg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } sseg_state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Index 15 is leftmost: F E d C b A 9 8 7 6 5 4 3 2 1 0
  localparam logic [15:0][6:0] SEG_TABLE = '{
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex2seg(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/swervolf_sseg_if.sv
// Bundle of the display scanner's data/control inputs and its display outputs.
// The master side supplies values and enables; the slave (scanner) drives the LEDs.
interface swervolf_sseg_if #(
   parameter int NUM_DIGITS = 8
);

   logic [4*NUM_DIGITS-1:0] i_value;
   logic [NUM_DIGITS-1:0]   i_dp;
   logic [NUM_DIGITS-1:0]   i_en;
   logic                    i_load;
   logic                    o_pending;
   logic                    o_frame;
   logic [NUM_DIGITS-1:0]   o_an;
   logic [6:0]              o_seg;
   logic                    o_dp;

   modport master (
      output i_value, i_dp, i_en, i_load,
      input  o_pending, o_frame, o_an, o_seg, o_dp
   );

   modport slave (
      input  i_value, i_dp, i_en, i_load,
      output o_pending, o_frame, o_an, o_seg, o_dp
   );

endinterface

// File: rtl/swervolf_sseg_decode.sv
// Combinational hex nibble to active-low seven-segment cathode pattern.
module swervolf_sseg_decode
   import swervolf_sseg_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);

   assign o_seg = hex2seg(i_nibble);

endmodule

// File: rtl/swervolf_sseg_scan.sv
// Time-multiplexed N-digit hex seven-segment driver with frame-aligned double buffering.
// Define SWERVOLF_SSEG_LZB_EN to blank leading zeros of the displayed value.
module swervolf_sseg_scan
   import swervolf_sseg_pkg::*;
#(
   parameter int NUM_DIGITS   = 8,
   parameter int DIV_CYCLES   = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic           clk,
   input  logic           rst,
   swervolf_sseg_if.slave bus
);

   if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_digits
      $error("swervolf_sseg_scan: NUM_DIGITS must be in 1..16");
   end
   if (BLANK_CYCLES < 1 || BLANK_CYCLES >= DIV_CYCLES) begin : g_bad_blank
      $error("swervolf_sseg_scan: need 1 <= BLANK_CYCLES < DIV_CYCLES");
   end

   localparam int CNT_W = $clog2(DIV_CYCLES);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   sseg_state_e                 state_q, state_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic [IDX_W-1:0]            idx_q, idx_d;
   logic                        frame_q, frame_d;
   logic                        pending_q, pending_d;
   logic [NUM_DIGITS-1:0][3:0]  pend_q, pend_d;
   logic [NUM_DIGITS-1:0]       pend_dp_q, pend_dp_d;
   logic [NUM_DIGITS-1:0][3:0]  disp_q, disp_d;
   logic [NUM_DIGITS-1:0]       disp_dp_q, disp_dp_d;
   logic [NUM_DIGITS-1:0]       an_q, an_d;
   logic [6:0]                  seg_q, seg_d;
   logic                        dpn_q, dpn_d;

   logic                        commit;
   logic                        lz_hide;
   logic [6:0]                  seg_raw;

   // Slot sequencer: cnt runs 0..DIV_CYCLES-1 across a whole slot; BLANK covers the first part.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      idx_d   = idx_q;
      frame_d = 1'b0;
      case (state_q)
         BLANK: begin
            if (cnt_q == BLANK_LAST) begin
               state_d = SHOW;
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  frame_d = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         SHOW: begin
            if (cnt_q == DIV_LAST) begin
               state_d = BLANK;
               cnt_d   = '0;
            end
         end
         default: ;
      endcase
   end

   // Commit spans the edge entering the frame-start cycle and the frame-start cycle itself,
   // so a load landing on either shows up in the frame that is just beginning.
   assign commit = frame_d | frame_q;

   always_comb begin
      pend_d    = pend_q;
      pend_dp_d = pend_dp_q;
      pending_d = pending_q;
      disp_d    = disp_q;
      disp_dp_d = disp_dp_q;
      if (bus.i_load) begin
         pend_d    = bus.i_value;
         pend_dp_d = bus.i_dp;
         pending_d = 1'b1;
      end
      if (commit) begin
         disp_d    = pend_d;
         disp_dp_d = pend_dp_d;
         pending_d = 1'b0;
      end
   end

`ifdef SWERVOLF_SSEG_LZB_EN
   logic [IDX_W-1:0] lz_top;
`endif

   always_comb begin
      lz_hide = 1'b0;
`ifdef SWERVOLF_SSEG_LZB_EN
      lz_top = '0;
      for (int d = 1; d < NUM_DIGITS; d++) begin
         if (disp_d[d] != 4'h0) lz_top = IDX_W'(d);
      end
      lz_hide = (idx_d > lz_top);
`endif
   end

   swervolf_sseg_decode u_decode (
      .i_nibble (disp_d[idx_d]),
      .o_seg    (seg_raw)
   );

   // Outputs are registered from next-state values so they line up with the slot state.
   always_comb begin
      an_d  = '1;
      seg_d = SEG_OFF;
      dpn_d = 1'b1;
      if (state_d == SHOW && bus.i_en[idx_d] && !lz_hide) begin
         an_d[idx_d] = 1'b0;
         seg_d       = seg_raw;
         dpn_d       = ~disp_dp_d[idx_d];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= BLANK;
         cnt_q     <= '0;
         idx_q     <= IDX_LAST;
         frame_q   <= 1'b0;
         pending_q <= 1'b0;
         // NOTE: the display buffers are reset too, so the first frame after reset shows zeros.
         pend_q    <= '0;
         pend_dp_q <= '0;
         disp_q    <= '0;
         disp_dp_q <= '0;
         an_q      <= '1;
         seg_q     <= SEG_OFF;
         dpn_q     <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         frame_q   <= frame_d;
         pending_q <= pending_d;
         pend_q    <= pend_d;
         pend_dp_q <= pend_dp_d;
         disp_q    <= disp_d;
         disp_dp_q <= disp_dp_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
         dpn_q     <= dpn_d;
      end
   end

   assign bus.o_pending = pending_q;
   assign bus.o_frame   = frame_q;
   assign bus.o_an      = an_q;
   assign bus.o_seg     = seg_q;
   assign bus.o_dp      = dpn_q;

endmodule
